// File: rtl/mv_load_ctrl.sv
// Sequencer loading one (uni) or two (bi) MV words into the MV0/MV1 registers, then starting or bypassing the filter.
// Optional watchdog on the filter wait: define MV_WDOG_EN.
module mv_load_ctrl #(
    parameter int MV_W           = 8,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             CLK,
    input  logic             RST_SYNC,
    input  logic             MV_VALID,
    input  logic             MV_BI,
    input  logic [MV_W-1:0]  MV_IN,
    output logic             MV_READY,
    output logic             WE_MV_0,
    output logic             WE_MV_1,
    output logic [MV_W-1:0]  MV_OUT,
    output logic [1:0]       FRAC_H,
    output logic [1:0]       FRAC_V,
    output logic             INTERP_START,
    input  logic             INTERP_DONE,
    output logic             BYPASS,
    output logic             BUSY,
    output logic             BLK_DONE,
    output logic [CNT_W-1:0] BLK_CNT,
    output logic             ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR0,
        S_GET1,
        S_WR1,
        S_START,
        S_WAIT,
        S_FIN
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mv_load_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    state_t            r_state;
    logic              r_bi;
    logic [MV_W-1:0]   r_mv;
    logic [1:0]        r_fh;
    logic [1:0]        r_fv;
    logic              r_frac1_zero;
    logic              r_we0;
    logic              r_we1;
    logic              r_start;
    logic              r_bypass;
    logic              r_blk_done;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;

    logic              w_accept;
    logic              w_in_frac_zero;
    logic              w_full_pel;

`ifdef MV_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]   r_wd;
`endif

    assign MV_READY = !RST_SYNC && ((r_state == S_IDLE) || (r_state == S_GET1));
    assign BUSY     = (r_state != S_IDLE);
    assign w_accept = MV_VALID && MV_READY;

    assign w_in_frac_zero = (MV_IN[MV_W/2+1:MV_W/2] == 2'b00) && (MV_IN[1:0] == 2'b00);
    // MV1 fractions only matter for bi blocks; a stale flag from an earlier block is masked.
    assign w_full_pel = (r_fh == 2'b00) && (r_fv == 2'b00) && (!r_bi || r_frac1_zero);

    assign WE_MV_0      = r_we0;
    assign WE_MV_1      = r_we1;
    assign MV_OUT       = r_mv;
    assign FRAC_H       = r_fh;
    assign FRAC_V       = r_fv;
    assign INTERP_START = r_start;
    assign BYPASS       = r_bypass;
    assign BLK_DONE     = r_blk_done;
    assign BLK_CNT      = r_cnt;
    assign ERR          = r_err;

    always_ff @(posedge CLK) begin
        if (RST_SYNC) begin
            r_state      <= S_IDLE;
            r_bi         <= 1'b0;
            r_mv         <= '0;
            r_fh         <= '0;
            r_fv         <= '0;
            r_frac1_zero <= 1'b0;
            r_we0        <= 1'b0;
            r_we1        <= 1'b0;
            r_start      <= 1'b0;
            r_bypass     <= 1'b0;
            r_blk_done   <= 1'b0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
`ifdef MV_WDOG_EN
            r_wd         <= '0;
`endif
        end else begin
            r_we0      <= 1'b0;
            r_we1      <= 1'b0;
            r_start    <= 1'b0;
            r_bypass   <= 1'b0;
            r_blk_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mv    <= MV_IN;
                        r_bi    <= MV_BI;
                        r_fh    <= MV_IN[MV_W/2+1:MV_W/2];
                        r_fv    <= MV_IN[1:0];
                        r_we0   <= 1'b1;
                        r_state <= S_WR0;
                    end
                end
                S_WR0: begin
                    if (r_bi) begin
                        r_state <= S_GET1;
                    end else begin
                        r_start  <= !w_full_pel;
                        r_bypass <= w_full_pel;
                        r_state  <= S_START;
                    end
                end
                S_GET1: begin
                    if (w_accept) begin
                        r_mv         <= MV_IN;
                        r_frac1_zero <= w_in_frac_zero;
                        r_we1        <= 1'b1;
                        r_state      <= S_WR1;
                    end
                end
                S_WR1: begin
                    r_start  <= !w_full_pel;
                    r_bypass <= w_full_pel;
                    r_state  <= S_START;
                end
                S_START: begin
                    if (r_bypass) begin
                        r_blk_done <= 1'b1;
                        r_cnt      <= r_cnt + 1'b1;
                        r_state    <= S_FIN;
                    end else begin
`ifdef MV_WDOG_EN
                        r_wd    <= '0;
`endif
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (INTERP_DONE) begin
                        r_blk_done <= 1'b1;
                        r_cnt      <= r_cnt + 1'b1;
                        r_state    <= S_FIN;
                    end
`ifdef MV_WDOG_EN
                    else if (r_wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        // Aborted block: report completion but leave the count alone.
                        r_err      <= 1'b1;
                        r_blk_done <= 1'b1;
                        r_state    <= S_FIN;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
`endif
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
